bus_arbiter: RTL

- Two-master arbiter that shares one RAM/peripheral bus between the CPU and the GPU framebuffer fetch port.
- Serialises accesses and inserts programmable wait states for slow slaves.
- Returns read data and a one-cycle acknowledge to the winning master.
- Sits between the masters and the chip-select decode that drives Ram/Gpu strobes.

---
 rtl/bus_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master (CPU / GPU fetch) arbiter for a shared RAM/peripheral bus.
// Each access holds its strobe for ACCESS_CYCLES cycles, then acks the winner for one cycle.
module bus_arbiter #(
    parameter int ACCESS_CYCLES = 1,
    parameter bit FAIR          = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write,
    input  logic        cpu_read,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic [15:0] gfx_address,
    input  logic [7:0]  gfx_wdata,
    input  logic        gfx_write,
    input  logic        gfx_read,
    output logic [7:0]  gfx_rdata,
    output logic        gfx_ack,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_wdata,
    output logic        bus_write,
    output logic        bus_read,
    input  logic [7:0]  bus_rdata,
    output logic        grant_cpu,
    output logic        grant_gfx,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] LOAD = 4'(ACCESS_CYCLES - 1);

    state_t      state;
    logic [3:0]  count;
    logic        is_write;
    logic        owner_gfx;
    logic        last_gfx;

    logic        cpu_req;
    logic        gfx_req;
    logic        pick_gfx;
    logic        sel_write;
    logic [15:0] sel_address;
    logic [7:0]  sel_wdata;

    // A simultaneous write+read request is treated as a write.
    always_comb begin
        cpu_req     = cpu_write | cpu_read;
        gfx_req     = gfx_write | gfx_read;
        pick_gfx    = gfx_req && (!cpu_req || (FAIR && !last_gfx));
        sel_write   = pick_gfx ? gfx_write : cpu_write;
        sel_address = pick_gfx ? gfx_address : cpu_address;
        sel_wdata   = pick_gfx ? gfx_wdata : cpu_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            is_write    <= 1'b0;
            owner_gfx   <= 1'b0;
            last_gfx    <= 1'b1;
            bus_address <= '0;
            bus_wdata   <= '0;
            bus_write   <= 1'b0;
            bus_read    <= 1'b0;
            cpu_rdata   <= '0;
            gfx_rdata   <= '0;
            cpu_ack     <= 1'b0;
            gfx_ack     <= 1'b0;
            grant_cpu   <= 1'b0;
            grant_gfx   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || gfx_req) begin
                        state       <= ACCESS;
                        busy        <= 1'b1;
                        owner_gfx   <= pick_gfx;
                        last_gfx    <= pick_gfx;
                        count       <= LOAD;
                        is_write    <= sel_write;
                        bus_write   <= sel_write;
                        bus_read    <= !sel_write;
                        bus_address <= sel_address;
                        bus_wdata   <= sel_wdata;
                        grant_cpu   <= !pick_gfx;
                        grant_gfx   <= pick_gfx;
                    end
                end
                ACCESS: begin
                    if (count == 4'd0) begin
                        // Slave data is only trusted on the final strobe cycle.
                        state     <= DONE;
                        bus_write <= 1'b0;
                        bus_read  <= 1'b0;
                        cpu_ack   <= !owner_gfx;
                        gfx_ack   <= owner_gfx;
                        if (!is_write) begin
                            if (owner_gfx) gfx_rdata <= bus_rdata;
                            else           cpu_rdata <= bus_rdata;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    cpu_ack     <= 1'b0;
                    gfx_ack     <= 1'b0;
                    grant_cpu   <= 1'b0;
                    grant_gfx   <= 1'b0;
                    busy        <= 1'b0;
                    bus_address <= '0;
                    bus_wdata   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
